// File: rtl/pdm_pkg.sv
// Shared constants and types for the PDM microphone capture front end.
// Defaults: 20 MHz / 10 = 2 MHz bit clock, decimate by 64, 4th-order CIC.
package pdm_pkg;

    localparam int CLK_DIV_DEF   = 10;
    localparam int DECIM_DEF     = 64;
    localparam int CIC_ORDER_DEF = 4;

    // CIC gain is ratio^order; the extra two bits hold the sign and +full-scale.
    function automatic int cic_out_w(input int order, input int ratio);
        return order * $clog2(ratio) + 2;
    endfunction

    localparam int OUT_W_DEF = cic_out_w(CIC_ORDER_DEF, DECIM_DEF);

    typedef logic signed [OUT_W_DEF-1:0] pcm_t;

endpackage

// File: rtl/cic_decimator.sv
// One-channel CIC decimator: integrators at the bit rate, combs pipelined on tick.
// Latency: out_en follows tick by ORDER clk cycles.
// Backpressure: none; the consumer must take out_data on the out_en cycle.
module cic_decimator
    import pdm_pkg::*;
#(
    parameter int ORDER = CIC_ORDER_DEF,
    parameter int W     = OUT_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         in_en,
    input  logic         in_bit,
    input  logic         tick,
    output logic         out_en,
    output logic [W-1:0] out_data
);

    logic [ORDER-1:0][W-1:0] integ_q, integ_d;
    logic [ORDER-1:0][W-1:0] dly_q, dly_d;
    logic [ORDER-1:0][W-1:0] comb_q, comb_d;
    logic [ORDER-1:0]        vld_q, vld_d;
    logic [W-1:0]            x;

    always_comb begin
        x       = in_bit ? W'(1) : '1;
        integ_d = integ_q;
        dly_d   = dly_q;
        comb_d  = comb_q;
        vld_d   = '0;

        // Cascade uses the previous stage's old value; all sums wrap modulo 2^W.
        if (in_en) begin
            integ_d[0] = integ_q[0] + x;
            for (int i = 1; i < ORDER; i++) begin
                integ_d[i] = integ_q[i] + integ_q[i-1];
            end
        end

        vld_d[0] = tick;
        if (tick) begin
            comb_d[0] = integ_d[ORDER-1] - dly_q[0];
            dly_d[0]  = integ_d[ORDER-1];
        end
        for (int i = 1; i < ORDER; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                comb_d[i] = comb_q[i-1] - dly_q[i];
                dly_d[i]  = comb_q[i-1];
            end
        end

        if (clr) begin
            integ_d = '0;
            dly_d   = '0;
            comb_d  = '0;
            vld_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            integ_q <= '0;
            dly_q   <= '0;
            comb_q  <= '0;
            vld_q   <= '0;
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
            comb_q  <= comb_d;
            vld_q   <= vld_d;
        end
    end

    assign out_en   = vld_q[ORDER-1];
    assign out_data = comb_q[ORDER-1];

endmodule

// File: rtl/pdm_mic_capture.sv
// Stereo PDM mic capture: bit clock generation, L/R capture, dual CIC decimation.
// Latency: out_valid rises CIC_ORDER+1 clk cycles after the frame tick.
// Backpressure: one-deep output register; a result arriving while held is dropped and sets overrun.
module pdm_mic_capture
    import pdm_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int DECIM     = DECIM_DEF,
    parameter int CIC_ORDER = CIC_ORDER_DEF,
    parameter int OUT_W     = cic_out_w(CIC_ORDER, DECIM)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic             mic_clk,
    input  logic             pdm_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_left,
    output logic [OUT_W-1:0] out_right,
    output logic             overrun
);

    localparam int PH_W = $clog2(CLK_DIV);
    localparam int DC_W = $clog2(DECIM);
    localparam int WU_W = $clog2(CIC_ORDER + 1);

    localparam logic [PH_W-1:0] PH_LEFT = PH_W'(CLK_DIV / 2 - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV / 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECIM - 1);
    localparam logic [WU_W-1:0] WU_DONE = WU_W'(CIC_ORDER);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [DC_W-1:0]  dec_q, dec_d;
    logic [WU_W-1:0]  warm_q, warm_d;
    logic             mic_clk_q, mic_clk_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_left_q, out_left_d;
    logic [OUT_W-1:0] out_right_q, out_right_d;
    logic             overrun_q, overrun_d;

    logic             left_cap, right_cap, frame_tick;
    logic             l_done, r_done, comb_done, result;
    logic [OUT_W-1:0] l_pcm, r_pcm;

    // Captures land on the last count of each half so the data has a full half-period to settle.
    assign left_cap   = enable && (phase_q == PH_LEFT);
    assign right_cap  = enable && (phase_q == PH_LAST);
    assign frame_tick = right_cap && (dec_q == DC_LAST);
    assign comb_done  = l_done && r_done;
    assign result     = comb_done && (warm_q == WU_DONE);

    cic_decimator #(.ORDER(CIC_ORDER), .W(OUT_W)) u_cic_left (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (!enable),
        .in_en    (left_cap),
        .in_bit   (pdm_data),
        .tick     (frame_tick),
        .out_en   (l_done),
        .out_data (l_pcm)
    );

    cic_decimator #(.ORDER(CIC_ORDER), .W(OUT_W)) u_cic_right (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (!enable),
        .in_en    (right_cap),
        .in_bit   (pdm_data),
        .tick     (frame_tick),
        .out_en   (r_done),
        .out_data (r_pcm)
    );

    always_comb begin
        phase_d     = '0;
        dec_d       = '0;
        warm_d      = '0;
        mic_clk_d   = 1'b0;
        out_valid_d = 1'b0;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        overrun_d   = overrun_q;

        if (enable) begin
            phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            mic_clk_d = (phase_q < PH_HIGH);
            dec_d     = dec_q;
            warm_d    = warm_q;
            if (right_cap) begin
                dec_d = (dec_q == DC_LAST) ? '0 : dec_q + DC_W'(1);
            end
            // The first CIC_ORDER results see combs still filling from zero.
            if (comb_done && (warm_q != WU_DONE)) begin
                warm_d = warm_q + WU_W'(1);
            end

            out_valid_d = out_valid_q;
            if (result) begin
                if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    out_left_d  = l_pcm;
                    out_right_d = r_pcm;
                end else begin
                    overrun_d = 1'b1;
                end
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= '0;
            dec_q       <= '0;
            warm_q      <= '0;
            mic_clk_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            dec_q       <= dec_d;
            warm_q      <= warm_d;
            mic_clk_q   <= mic_clk_d;
            out_valid_q <= out_valid_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mic_clk   = mic_clk_q;
    assign out_valid = out_valid_q;
    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Directed bench for pdm_mic_capture with a queue of expected PCM pairs and their arrival edges.
`timescale 1ns/1ps
module tb_pdm_mic_capture;
    import pdm_pkg::*;

    localparam int PERIOD = DECIM_DEF * CLK_DIV_DEF;
    localparam int FIRST  = (CLK_DIV_DEF - 1) + (DECIM_DEF - 1) * CLK_DIV_DEF
                          + CIC_ORDER_DEF + CIC_ORDER_DEF * PERIOD;
    localparam int WARM   = FIRST - PERIOD;
    localparam pcm_t POS  = pcm_t'(1) <<< 24;
    localparam pcm_t NEG  = -POS;
    localparam pcm_t ZERO = '0;

    localparam int M_ONES = 0, M_ZEROS = 1, M_STRICT = 2, M_ALT = 3;

    typedef struct {
        pcm_t l;
        pcm_t r;
        int   at;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 mic_clk;
    logic                 pdm_data = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [OUT_W_DEF-1:0] out_left;
    logic [OUT_W_DEF-1:0] out_right;
    logic                 overrun;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   idx    = 0;
    int   mode   = M_ONES;
    int   pos    = 0;
    logic mic_prev = 1'b0;
    logic lbit = 1'b0;
    logic rbit = 1'b0;
    exp_t sb[$];

    pdm_mic_capture dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .mic_clk   (mic_clk),
        .pdm_data  (pdm_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_left  (out_left),
        .out_right (out_right),
        .overrun   (overrun)
    );

    initial forever #25 clk = ~clk;

    // Microphone model: pos counts negedges since the last mic_clk rise; phase p is driven at pos p-1.
    initial forever begin
        @(negedge clk);
        if (mic_clk && !mic_prev) begin
            pos  = 0;
            rbit = ~rbit;
        end else begin
            pos++;
        end
        if (!mic_clk && mic_prev) lbit = ~lbit;
        mic_prev = mic_clk;
        case (mode)
            M_ONES:   pdm_data = 1'b1;
            M_ZEROS:  pdm_data = 1'b0;
            M_STRICT: pdm_data = (pos == 3) ? 1'b1 : (pos == 8) ? 1'b0 : (pos >= 4 && pos <= 7);
            default:  pdm_data = mic_clk ? lbit : rbit;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic goto(input int e);
        while (idx < e) begin
            @(negedge clk);
            idx++;
        end
    endtask

    task automatic start_run(input int m);
        mode   = m;
        enable = 1'b1;
        idx    = -1;
    endtask

    task automatic expect_next(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'(1));
        end else begin
            e = sb.pop_front();
            goto(e.at);
            chk({tag, "_vld"}, 32'(out_valid), 32'(1));
            chk({tag, "_left"}, 32'(out_left), 32'($unsigned(e.l)));
            chk({tag, "_right"}, 32'(out_right), 32'($unsigned(e.r)));
        end
    endtask

    initial begin
        logic [19:0] clk_obs;
        logic [19:0] clk_exp;

        repeat (3) @(negedge clk);
        chk("rst_mic_clk", 32'(mic_clk), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_left", 32'(out_left), 32'(0));
        chk("rst_right", 32'(out_right), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Constant ones: bit clock shape, warm-up, latency, same-cycle consume+load.
        start_run(M_ONES);
        chk("pre_mic_clk", 32'(mic_clk), 32'(0));
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            idx++;
            clk_obs[n] = mic_clk;
            clk_exp[n] = ((n % CLK_DIV_DEF) < CLK_DIV_DEF / 2);
        end
        chk("mic_clk_shape", 32'(clk_obs), 32'(clk_exp));
        sb.push_back('{POS, POS, FIRST});
        goto(WARM);
        chk("ones_warmup", 32'(out_valid), 32'(0));
        expect_next("ones_p5");
        goto(FIRST + 1);
        chk("ones_clear", 32'(out_valid), 32'(0));
        out_ready = 1'b0;
        goto(FIRST + PERIOD);
        chk("ones_p6_held", 32'(out_valid), 32'(1));
        goto(FIRST + 2 * PERIOD - 1);
        chk("ones_p6_still", 32'(out_valid), 32'(1));
        out_ready = 1'b1;
        sb.push_back('{POS, POS, FIRST + 2 * PERIOD});
        expect_next("ones_same_cycle");
        chk("same_cycle_ovr", 32'(overrun), 32'(0));
        goto(FIRST + 2 * PERIOD + 1);
        chk("same_cycle_clear", 32'(out_valid), 32'(0));
        enable = 1'b0;
        goto(FIRST + 2 * PERIOD + 3);

        // Left 1 / right 0, driven correctly only on the capture cycles; then enable drop.
        start_run(M_STRICT);
        sb.push_back('{POS, NEG, FIRST});
        sb.push_back('{POS, NEG, FIRST + 2 * PERIOD});
        goto(WARM);
        chk("strict_warmup", 32'(out_valid), 32'(0));
        expect_next("strict_p5");
        goto(FIRST + 2 * PERIOD - 1);
        out_ready = 1'b0;
        expect_next("strict_p7");
        goto(4800);
        chk("drop_pre_mic_clk", 32'(mic_clk), 32'(1));
        enable = 1'b0;
        goto(4801);
        chk("drop_mic_clk", 32'(mic_clk), 32'(0));
        chk("drop_valid", 32'(out_valid), 32'(0));
        chk("drop_hold_left", 32'(out_left), 32'($unsigned(POS)));
        chk("drop_hold_right", 32'(out_right), 32'($unsigned(NEG)));
        out_ready = 1'b1;
        goto(4803);
        start_run(M_STRICT);
        sb.push_back('{POS, NEG, FIRST});
        goto(WARM);
        chk("reen_warmup", 32'(out_valid), 32'(0));
        expect_next("reen_p5");
        enable = 1'b0;
        goto(FIRST + 3);

        // Alternating bits per channel settle to zero.
        start_run(M_ALT);
        sb.push_back('{ZERO, ZERO, FIRST});
        sb.push_back('{ZERO, ZERO, FIRST + PERIOD});
        expect_next("alt_p5");
        expect_next("alt_p6");
        enable = 1'b0;
        goto(FIRST + PERIOD + 3);

        // Overrun: hold one pair across the next completion, release, then async reset.
        out_ready = 1'b0;
        start_run(M_ONES);
        sb.push_back('{POS, POS, FIRST});
        goto(WARM);
        chk("ovr_warmup", 32'(out_valid), 32'(0));
        expect_next("ovr_p5");
        mode = M_ZEROS;
        goto(FIRST + PERIOD - 1);
        chk("ovr_before", 32'(overrun), 32'(0));
        goto(FIRST + PERIOD);
        chk("ovr_set", 32'(overrun), 32'(1));
        chk("ovr_valid", 32'(out_valid), 32'(1));
        chk("ovr_held_left", 32'(out_left), 32'($unsigned(POS)));
        chk("ovr_held_right", 32'(out_right), 32'($unsigned(POS)));
        out_ready = 1'b1;
        goto(FIRST + PERIOD + 1);
        chk("release_clear", 32'(out_valid), 32'(0));
        chk("ovr_sticky", 32'(overrun), 32'(1));
        out_ready = 1'b0;
        goto(FIRST + 2 * PERIOD);
        chk("p7_valid", 32'(out_valid), 32'(1));
        chk("pre_rst_mic_clk", 32'(mic_clk), 32'(1));
        #5 reset_n = 1'b0;
        #1;
        chk("arst_mic_clk", 32'(mic_clk), 32'(0));
        chk("arst_valid", 32'(out_valid), 32'(0));
        chk("arst_left", 32'(out_left), 32'(0));
        chk("arst_right", 32'(out_right), 32'(0));
        chk("arst_overrun", 32'(overrun), 32'(0));
        #4 reset_n = 1'b1;
        enable = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
